spike_readout: RTL and testbench

- Readout end of the spike path; consumes the 250-bit spike frames the packet loader emits (spike_winc / spike_out) once per tick.
- Buffers whole frames in a small synchronous FIFO and serializes each one into 32-bit words for the CPU-facing register interface.
- Single clock domain (snn clock); the CPU bridge performs any crossing upstream.

---
 rtl/spike_readout_pkg.sv | 35 +++
 rtl/spike_readout_if.sv | 13 +
 rtl/spike_frame_fifo.sv | 58 +++++
 rtl/spike_readout.sv | 107 ++++++++++
 tb/tb_spike_readout.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/spike_readout_pkg.sv
// Shared constants, FSM encoding and helpers for the spike readout path.
// SPIKE_READOUT_POPCOUNT_EN adds a ninth per-frame word carrying the spike popcount.
package spike_readout_pkg;

  localparam int SPIKE_W = 250;
  localparam int WORD_W  = 32;
  localparam int PAD_W   = 6;

`ifdef SPIKE_READOUT_POPCOUNT_EN
  localparam int WORDS_PER_FRAME = 9;
  localparam int PC_W            = 8;
`else
  localparam int WORDS_PER_FRAME = 8;
  localparam int PC_W            = 0;
`endif

  // Stored frame: optional popcount in the top bits, raw spikes below.
  localparam int FRAME_W = SPIKE_W + PC_W;
  localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_FRAME - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    SERVE = 1'b1
  } state_t;

`ifdef SPIKE_READOUT_POPCOUNT_EN
  function automatic logic [7:0] popcount(input logic [SPIKE_W-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < SPIKE_W; i++) n = n + 8'(v[i]);
    return n;
  endfunction
`endif

endpackage

// File: rtl/spike_readout_if.sv
// CPU-facing word read port: rd_req pulse in, rd_data/rd_ack one cycle later.
interface spike_readout_if;
  import spike_readout_pkg::*;

  // Handshake: every rd_req cycle is accepted and answered by exactly one
  // rd_ack cycle on the following clock, with rd_data valid while rd_ack is high.
  logic              rd_req;
  logic [WORD_W-1:0] rd_data;
  logic              rd_ack;

  modport master (output rd_req, input  rd_data, input  rd_ack);
  modport slave  (input  rd_req, output rd_data, output rd_ack);
endinterface

// File: rtl/spike_frame_fifo.sv
// Synchronous whole-frame FIFO; a push into a full FIFO is accepted only when
// the same cycle pops, so the freed slot is reused immediately.
module spike_frame_fifo #(
  parameter int DW    = 250,
  parameter int ASIZE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DW-1:0]    data_i,
  output logic [DW-1:0]    data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [ASIZE:0]   count_o
);
  localparam int DEPTH = 1 << ASIZE;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [ASIZE-1:0] wr_ptr_q, rd_ptr_q;
  logic [ASIZE:0]   count_q, count_d;
  logic             empty_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (ASIZE+1)'(DEPTH));
  assign pop_ok  = pop_i && !empty_q;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = empty_q;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
    end
  end
endmodule

// File: rtl/spike_readout.sv
// Buffers 250-bit spike frames and serializes each into 32-bit readout words.
// Define SPIKE_READOUT_POPCOUNT_EN to append a popcount word to every frame.
module spike_readout
  import spike_readout_pkg::*;
#(
  parameter int ASIZE  = 2,
  parameter int WORD_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               spike_winc,
  input  logic [SPIKE_W-1:0] spike_in,
  input  logic               clr_overflow,
  spike_readout_if.slave     rd_if,
  output logic               frame_avail,
  output logic [ASIZE:0]     frame_count,
  output logic [3:0]         word_idx,
  output logic               overflow,
  output state_t             fsm_state_o
);
  if (WORD_W != 32) begin : g_bad_word_w
    $error("spike_readout: WORD_W must be 32");
  end

  state_t                 state_q;
  logic [3:0]             word_idx_q;
  logic [31:0]            rd_data_q;
  logic                   rd_ack_q;
  logic                   overflow_q;
  logic [FRAME_W-1:0]     head, wr_frame;
  logic [7:0][31:0]       padded_words;
  logic [31:0]            cur_word;
  logic                   fifo_full, fifo_empty;
  logic                   pop, drop;

`ifdef SPIKE_READOUT_POPCOUNT_EN
  assign wr_frame = {popcount(spike_in), spike_in};
`else
  assign wr_frame = spike_in;
`endif

  // The head frame is popped on the read that returns its last word.
  assign pop  = (state_q == SERVE) && rd_if.rd_req && (word_idx_q == LAST_WORD);
  assign drop = spike_winc && fifo_full && !pop;

  spike_frame_fifo #(.DW(FRAME_W), .ASIZE(ASIZE)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (spike_winc),
    .pop_i   (pop),
    .data_i  (wr_frame),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (frame_count)
  );

  // Element 7 holds padded bits 255:224, i.e. word 0 with neuron 0 at its MSB.
  assign padded_words = {head[SPIKE_W-1:0], {PAD_W{1'b0}}};

  always_comb begin
    cur_word = padded_words[3'd7 - word_idx_q[2:0]];
`ifdef SPIKE_READOUT_POPCOUNT_EN
    if (word_idx_q == 4'd8) cur_word = {24'b0, head[FRAME_W-1 -: 8]};
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      word_idx_q <= '0;
      rd_data_q  <= '0;
      rd_ack_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_ack_q <= rd_if.rd_req;
      case (state_q)
        EMPTY: begin
          if (rd_if.rd_req) rd_data_q <= '0;
          if (spike_winc)   state_q   <= SERVE;
        end
        SERVE: begin
          if (rd_if.rd_req) begin
            rd_data_q <= cur_word;
            if (word_idx_q == LAST_WORD) begin
              word_idx_q <= '0;
              if (frame_count == (ASIZE+1)'(1) && !spike_winc) state_q <= EMPTY;
            end else begin
              word_idx_q <= word_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
      // A new drop outranks a same-cycle clear.
      if (drop)              overflow_q <= 1'b1;
      else if (clr_overflow) overflow_q <= 1'b0;
    end
  end

  assign rd_if.rd_data = rd_data_q;
  assign rd_if.rd_ack  = rd_ack_q;
  assign frame_avail   = !fifo_empty;
  assign word_idx      = word_idx_q;
  assign overflow      = overflow_q;
  assign fsm_state_o   = state_q;
endmodule

// File: tb/tb_spike_readout.sv
// Randomized bench for spike_readout against a frame-queue reference model.
module tb_spike_readout;
  import spike_readout_pkg::*;

  localparam int ASIZE = 2;
  localparam int DEPTH = 1 << ASIZE;
`ifdef SPIKE_READOUT_POPCOUNT_EN
  localparam int NW = 9;
`else
  localparam int NW = 8;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic               spike_winc;
  logic [SPIKE_W-1:0] spike_in;
  logic               clr_overflow;
  logic               frame_avail;
  logic [ASIZE:0]     frame_count;
  logic [3:0]         word_idx;
  logic               overflow;
  state_t             dut_state;

  spike_readout_if dif ();

  spike_readout #(.ASIZE(ASIZE), .WORD_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spike_winc   (spike_winc),
    .spike_in     (spike_in),
    .clr_overflow (clr_overflow),
    .rd_if        (dif),
    .frame_avail  (frame_avail),
    .frame_count  (frame_count),
    .word_idx     (word_idx),
    .overflow     (overflow),
    .fsm_state_o  (dut_state)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [SPIKE_W-1:0] exp_q[$];
  int                 m_widx;
  logic               m_ovf;
  logic               m_ack;
  logic [31:0]        m_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [SPIKE_W-1:0] f, input int k);
    logic [255:0] p;
    p = {f, 6'b0};
    if (k == 8) return 32'($countones(f));
    return p[255 - 32*k -: 32];
  endfunction

  task automatic check_all();
    check("rd_ack", 32'(dif.rd_ack), 32'(m_ack));
    if (m_ack) check("rd_data", dif.rd_data, m_data);
    check("frame_count", 32'(frame_count), 32'(exp_q.size()));
    check("frame_avail", 32'(frame_avail), 32'(exp_q.size() != 0));
    check("word_idx", 32'(word_idx), 32'(m_widx));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("fsm_state", 32'(dut_state), 32'(exp_q.size() != 0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0; spike_winc = 1'b0; spike_in = '0;
    clr_overflow = 1'b0; dif.rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    m_widx = 0; m_ovf = 1'b0; m_ack = 1'b0; m_data = '0;
    check("reset_rd_data", dif.rd_data, 32'h0);
    check_all();
  endtask

  task automatic do_cycle(input logic winc, input logic [SPIKE_W-1:0] f,
                          input logic rq, input logic clr);
    logic drop;
    spike_winc = winc; spike_in = f; dif.rd_req = rq; clr_overflow = clr;
    m_ack = rq;
    if (rq) begin
      if (exp_q.size() == 0) m_data = '0;
      else begin
        m_data = word_of(exp_q[0], m_widx);
        m_widx++;
        if (m_widx == NW) begin
          m_widx = 0;
          void'(exp_q.pop_front());
        end
      end
    end
    drop = 1'b0;
    if (winc) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(f);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);
    check("drained", 32'(frame_count), 32'h0);
  endtask

  function automatic logic [SPIKE_W-1:0] rand_frame();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom();
    return t[SPIKE_W-1:0];
  endfunction

  initial begin
    logic [SPIKE_W-1:0] f;
    do_reset();

    // Read while empty returns zero
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    check("empty_read", dif.rd_data, 32'h0);

    // Neuron 0 only
    f = '0; f[SPIKE_W-1] = 1'b1;
    do_cycle(1'b1, f, 1'b0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    check("nrn0_w0", dif.rd_data, 32'h8000_0000);
    drain();

    // Neuron 249 only
    f = '0; f[0] = 1'b1;
    do_cycle(1'b1, f, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) do_cycle(1'b0, '0, 1'b1, 1'b0);
    check("nrn249_w7", dif.rd_data, 32'h0000_0040);
    drain();

    // Overflow on fifth write, then clear
    for (int i = 0; i < 5; i++) do_cycle(1'b1, rand_frame(), 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_count", 32'(frame_count), 32'(DEPTH));
    do_cycle(1'b0, '0, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow), 32'h0);

    // Write into full FIFO on the cycle the head frame pops
    for (int k = 0; k < NW - 1; k++) do_cycle(1'b0, '0, 1'b1, 1'b0);
    do_cycle(1'b1, rand_frame(), 1'b1, 1'b0);
    check("full_pop_cnt", 32'(frame_count), 32'(DEPTH));
    check("full_pop_ovf", 32'(overflow), 32'h0);
    drain();

`ifdef SPIKE_READOUT_POPCOUNT_EN
    f = '1;
    do_cycle(1'b1, f, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      do_cycle(1'b0, '0, 1'b1, 1'b0);
      check("ones_word", dif.rd_data,
            (k < 7) ? 32'hFFFF_FFFF : (k == 7) ? 32'hFFFF_FFC0 : 32'h0000_00FA);
    end
`endif

    // Randomized traffic with a reset in the middle
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) do_reset();
      do_cycle($urandom_range(0, 5) == 0, rand_frame(),
               $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
